morra_match_driver: RTL and testbench

//  Drives a MorraCinese (rock-paper-scissors) game engine from the player side of its interface.

---
 rtl/morra_match_driver.sv | 212 +++++++++++++++++++++
 tb/tb_morra_match_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morra_match_driver.sv
// morra_match_driver: player-side traffic source for a MorraCinese game engine.
// Configures a game, streams one LFSR move pair per cycle, scores each manche
// one cycle after its pair was issued and flags engine verdicts that break the rules.
module morra_match_driver #(
    parameter logic [7:0]  SEED1     = 8'hA5,
    parameter logic [7:0]  SEED2     = 8'h3C,
    parameter bit          ALLOW_INV = 1'b0,
    parameter int unsigned TIMEOUT   = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] rounds_cfg,
    output logic       INIZIA,
    output logic [1:0] PRIMO,
    output logic [1:0] SECONDO,
    input  logic [1:0] MANCHE,
    input  logic [1:0] PARTITA,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic [4:0] p1_wins,
    output logic [4:0] p2_wins,
    output logic [4:0] draws,
    output logic [4:0] invalids,
    output logic       mismatch,
    output logic       timeout
);

    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONFIG,
        S_PLAY,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    lfsr1_q, lfsr1_d;
    logic [7:0]    lfsr2_q, lfsr2_d;
    logic [IW-1:0] issued_q, issued_d;
    logic          hist_valid_q, hist_valid_d;
    logic [1:0]    hist_p1_q, hist_p1_d;
    logic [1:0]    hist_p2_q, hist_p2_d;
    logic [1:0]    result_q, result_d;
    logic [4:0]    p1_wins_q, p1_wins_d;
    logic [4:0]    p2_wins_q, p2_wins_d;
    logic [4:0]    draws_q, draws_d;
    logic [4:0]    invalids_q, invalids_d;
    logic          mismatch_q, mismatch_d;
    logic          timeout_q, timeout_d;
    logic [1:0]    move1, move2;

    // Fibonacci LFSR, taps 8,6,5,4
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Low two LFSR bits become a move; 00 is either kept as invalid or folded to rock
    function automatic logic [1:0] to_move(input logic [7:0] s);
        if (s[1:0] == 2'b00 && !ALLOW_INV) begin
            return 2'b01;
        end
        return s[1:0];
    endfunction

    // Outcome the rules dictate: 01 P1 wins, 10 P2 wins, 11 draw, 00 invalid pair
    function automatic logic [1:0] rule_outcome(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'b00 || b == 2'b00) begin
            return 2'b00;
        end
        if (a == b) begin
            return 2'b11;
        end
        if ((a == 2'b10 && b == 2'b01) || (a == 2'b01 && b == 2'b11) ||
            (a == 2'b11 && b == 2'b10)) begin
            return 2'b01;
        end
        return 2'b10;
    endfunction

    function automatic logic [4:0] sat_inc(input logic [4:0] c);
        return (c == 5'd31) ? c : c + 5'd1;
    endfunction

    // Next-state, scoring and engine-facing outputs
    always_comb begin
        state_d      = state_q;
        lfsr1_d      = lfsr1_q;
        lfsr2_d      = lfsr2_q;
        issued_d     = issued_q;
        hist_valid_d = hist_valid_q;
        hist_p1_d    = hist_p1_q;
        hist_p2_d    = hist_p2_q;
        result_d     = result_q;
        p1_wins_d    = p1_wins_q;
        p2_wins_d    = p2_wins_q;
        draws_d      = draws_q;
        invalids_d   = invalids_q;
        mismatch_d   = mismatch_q;
        timeout_d    = timeout_q;
        INIZIA       = 1'b0;
        PRIMO        = 2'b00;
        SECONDO      = 2'b00;
        move1        = to_move(lfsr1_q);
        move2        = to_move(lfsr2_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_CONFIG;
                    issued_d     = '0;
                    hist_valid_d = 1'b0;
                    result_d     = 2'b00;
                    p1_wins_d    = '0;
                    p2_wins_d    = '0;
                    draws_d      = '0;
                    invalids_d   = '0;
                    mismatch_d   = 1'b0;
                    timeout_d    = 1'b0;
                end
            end
            S_CONFIG: begin
                INIZIA  = 1'b1;
                PRIMO   = rounds_cfg[3:2];
                SECONDO = rounds_cfg[1:0];
                state_d = S_PLAY;
            end
            S_PLAY: begin
                PRIMO        = move1;
                SECONDO      = move2;
                lfsr1_d      = lfsr_next(lfsr1_q);
                lfsr2_d      = lfsr_next(lfsr2_q);
                issued_d     = issued_q + 1'b1;
                hist_valid_d = 1'b1;
                hist_p1_d    = move1;
                hist_p2_d    = move2;
                // MANCHE this cycle answers the pair issued last cycle
                if (hist_valid_q) begin
                    case (MANCHE)
                        2'b01:   p1_wins_d  = sat_inc(p1_wins_q);
                        2'b10:   p2_wins_d  = sat_inc(p2_wins_q);
                        2'b11:   draws_d    = sat_inc(draws_q);
                        default: invalids_d = sat_inc(invalids_q);
                    endcase
                    if (MANCHE != 2'b00 && MANCHE != rule_outcome(hist_p1_q, hist_p2_q)) begin
                        mismatch_d = 1'b1;
                    end
                end
                if (PARTITA != 2'b00) begin
                    state_d      = S_DONE;
                    result_d     = PARTITA;
                    hist_valid_d = 1'b0;
                end else if (issued_q == IW'(TIMEOUT - 1)) begin
                    state_d      = S_DONE;
                    timeout_d    = 1'b1;
                    result_d     = 2'b00;
                    hist_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy = (state_q == S_CONFIG) || (state_q == S_PLAY);
        done = (state_q == S_DONE);
    end

    // State and score registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lfsr1_q      <= SEED1;
            lfsr2_q      <= SEED2;
            issued_q     <= '0;
            hist_valid_q <= 1'b0;
            hist_p1_q    <= 2'b00;
            hist_p2_q    <= 2'b00;
            result_q     <= 2'b00;
            p1_wins_q    <= '0;
            p2_wins_q    <= '0;
            draws_q      <= '0;
            invalids_q   <= '0;
            mismatch_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr1_q      <= lfsr1_d;
            lfsr2_q      <= lfsr2_d;
            issued_q     <= issued_d;
            hist_valid_q <= hist_valid_d;
            hist_p1_q    <= hist_p1_d;
            hist_p2_q    <= hist_p2_d;
            result_q     <= result_d;
            p1_wins_q    <= p1_wins_d;
            p2_wins_q    <= p2_wins_d;
            draws_q      <= draws_d;
            invalids_q   <= invalids_d;
            mismatch_q   <= mismatch_d;
            timeout_q    <= timeout_d;
        end
    end

    assign result   = result_q;
    assign p1_wins  = p1_wins_q;
    assign p2_wins  = p2_wins_q;
    assign draws    = draws_q;
    assign invalids = invalids_q;
    assign mismatch = mismatch_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_morra_match_driver.sv
// Directed bench for morra_match_driver: a model engine answers each issued pair,
// a queue of predicted move pairs is compared against the driver's outputs.
module tb_morra_match_driver;

    localparam int TMO = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] rounds_cfg;
    logic       INIZIA;
    logic [1:0] PRIMO;
    logic [1:0] SECONDO;
    logic [1:0] MANCHE;
    logic [1:0] PARTITA;
    logic       busy;
    logic       done;
    logic [1:0] result;
    logic [4:0] p1_wins;
    logic [4:0] p2_wins;
    logic [4:0] draws;
    logic [4:0] invalids;
    logic       mismatch;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] p1;
        logic [1:0] p2;
    } pair_t;

    pair_t      sb[$];
    logic [7:0] m_l1;
    logic [7:0] m_l2;

    morra_match_driver #(
        .SEED1    (8'hA5),
        .SEED2    (8'h3C),
        .ALLOW_INV(1'b0),
        .TIMEOUT  (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rounds_cfg(rounds_cfg),
        .INIZIA    (INIZIA),
        .PRIMO     (PRIMO),
        .SECONDO   (SECONDO),
        .MANCHE    (MANCHE),
        .PARTITA   (PARTITA),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .p1_wins   (p1_wins),
        .p2_wins   (p2_wins),
        .draws     (draws),
        .invalids  (invalids),
        .mismatch  (mismatch),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [1:0] m_move(input logic [7:0] s);
        logic [1:0] v;
        v = s[1:0];
        return (v == 2'b00) ? 2'b01 : v;
    endfunction

    // rock=1 paper=2 scissors=3: a beats b when (a-b) mod 3 == 1
    function automatic logic [1:0] m_rule(input logic [1:0] a, input logic [1:0] b);
        int d;
        d = (int'(a) - int'(b) + 3) % 3;
        if (d == 0) return 2'b11;
        if (d == 1) return 2'b01;
        return 2'b10;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_done"}, {7'd0, done}, 8'd0);
        chk({tag, "_inizia"}, {7'd0, INIZIA}, 8'd0);
        chk({tag, "_moves"}, {4'd0, PRIMO, SECONDO}, 8'd0);
        chk({tag, "_result"}, {6'd0, result}, 8'd0);
        chk({tag, "_counters"}, {3'd0, p1_wins} | {3'd0, p2_wins} | {3'd0, draws} | {3'd0, invalids}, 8'd0);
        chk({tag, "_flags"}, {6'd0, mismatch, timeout}, 8'd0);
    endtask

    // mode 0: correct engine, every 4th manche rejected (00)
    // mode 1: faulty engine, decisive verdicts swapped
    // mode 2: correct engine
    task automatic run_game(input string tag, input logic [3:0] cfg, input int mode,
                            input int end_k, input int start_at, input int rst_at);
        int    e_p1, e_p2, e_dr, e_inv, scored;
        logic  e_mis, e_to;
        logic  [1:0] e_res, verdict;
        logic  have_prev;
        pair_t prev, cur, got;

        e_p1 = 0; e_p2 = 0; e_dr = 0; e_inv = 0; scored = 0;
        e_mis = 1'b0; e_to = 1'b0; e_res = 2'b00; have_prev = 1'b0;
        prev.p1 = 2'b00; prev.p2 = 2'b00;

        @(negedge clk);
        start = 1'b1;
        rounds_cfg = cfg;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_cfg_inizia"}, {7'd0, INIZIA}, 8'd1);
        chk({tag, "_cfg_moves"}, {4'd0, PRIMO, SECONDO}, {4'd0, cfg});
        chk({tag, "_cfg_busy"}, {6'd0, busy, done}, 8'b10);
        chk({tag, "_cfg_clear"}, {3'd0, p1_wins} | {3'd0, invalids} | {6'd0, mismatch, timeout}, 8'd0);

        cur.p1 = m_move(m_l1);
        cur.p2 = m_move(m_l2);
        sb.push_back(cur);

        for (int k = 0; k < TMO; k++) begin
            @(posedge clk); #1;
            got = sb.pop_front();
            chk($sformatf("%s_pair%0d", tag, k), {4'd0, PRIMO, SECONDO}, {4'd0, got.p1, got.p2});
            chk($sformatf("%s_play%0d", tag, k), {6'd0, INIZIA, busy}, 8'b01);

            if (k == rst_at) begin
                rst = 1'b1;
                MANCHE = 2'b00;
                PARTITA = 2'b00;
                @(posedge clk); #1;
                rst = 1'b0;
                m_l1 = 8'hA5;
                m_l2 = 8'h3C;
                sb.delete();
                check_reset_state({tag, "_midrst"});
                return;
            end

            start = (k == start_at);
            if (have_prev) begin
                verdict = m_rule(prev.p1, prev.p2);
                if (mode == 0 && (k % 4) == 2) begin
                    verdict = 2'b00;
                end else if (mode == 1 && verdict != 2'b11) begin
                    verdict = ~verdict;
                end
                MANCHE = verdict;
                scored++;
                case (verdict)
                    2'b01:   e_p1++;
                    2'b10:   e_p2++;
                    2'b11:   e_dr++;
                    default: e_inv++;
                endcase
                if (verdict != 2'b00 && verdict != m_rule(prev.p1, prev.p2)) e_mis = 1'b1;
            end else begin
                MANCHE = 2'b00;
            end
            PARTITA = (k == end_k) ? 2'b01 : 2'b00;

            prev = got;
            have_prev = 1'b1;
            m_l1 = m_step(m_l1);
            m_l2 = m_step(m_l2);
            cur.p1 = m_move(m_l1);
            cur.p2 = m_move(m_l2);
            sb.push_back(cur);

            if (k == end_k) begin
                e_res = 2'b01;
                break;
            end
            if (k == TMO - 1) begin
                e_to = 1'b1;
                break;
            end
        end
        sb.delete();

        @(posedge clk); #1;
        start = 1'b0;
        MANCHE = 2'b00;
        PARTITA = 2'b00;
        chk({tag, "_done"}, {6'd0, busy, done}, 8'b01);
        chk({tag, "_result"}, {6'd0, result}, {6'd0, e_res});
        chk({tag, "_timeout"}, {7'd0, timeout}, {7'd0, e_to});
        chk({tag, "_p1"}, {3'd0, p1_wins}, 8'(e_p1));
        chk({tag, "_p2"}, {3'd0, p2_wins}, 8'(e_p2));
        chk({tag, "_draws"}, {3'd0, draws}, 8'(e_dr));
        chk({tag, "_inv"}, {3'd0, invalids}, 8'(e_inv));
        chk({tag, "_total"}, 8'(p1_wins) + 8'(p2_wins) + 8'(draws) + 8'(invalids), 8'(scored));
        chk({tag, "_mismatch"}, {7'd0, mismatch}, {7'd0, e_mis});
        chk({tag, "_done_moves"}, {4'd0, PRIMO, SECONDO}, 8'd0);

        // Results must hold while parked in DONE
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_hold"}, {done, mismatch, timeout, result, 3'd0}, {1'b1, e_mis, e_to, e_res, 3'd0});
        chk({tag, "_hold_cnt"}, 8'(p1_wins) + 8'(p2_wins) + 8'(draws) + 8'(invalids), 8'(scored));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b1;
        rounds_cfg = 4'd0;
        MANCHE = 2'b00;
        PARTITA = 2'b00;
        m_l1 = 8'hA5;
        m_l2 = 8'h3C;

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check_reset_state("idle");

        run_game("g5", 4'b0001, 0, 5, -1, -1);
        run_game("bad", 4'b0100, 1, 10, -1, -1);
        run_game("tmo", 4'b1010, 2, -1, -1, -1);
        run_game("abort", 4'b0011, 2, -1, 3, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
